triumph_ex_alu: RTL and testbench
=================================

TRIUMPH_EX_ALU -- requirements
Module: triumph_ex_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, width of the destination tag carried alongside each operation.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1, discards the in-flight and held operation.
REQ-006 SHALL have port in_valid_i, input, 1, operation offered.
REQ-007 SHALL have port in_ready_o, output, 1, operation can be accepted this cycle.
REQ-008 SHALL have port op_type_i, input, 4; the opcode is one of 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU or 10 MUL.
REQ-009 SHALL have ports op1_data_i and op2_data_i, input, XLEN each, source operands.
REQ-010 SHALL have port tag_i, input, TAG_W, destination tag.
REQ-011 SHALL have port out_valid_o, output, 1, result held for the WB stage.
REQ-012 SHALL have port out_ready_i, input, 1, WB stage consumes the result.
REQ-013 SHALL have ports op3_data_o (output, XLEN), tag_o (output, TAG_W) and illegal_o (output, 1, the opcode was unsupported).

Function
REQ-014 SHALL accept an operation only in a cycle where in_valid_i and in_ready_o are both high; all inputs are sampled in that cycle.
REQ-015 SHALL drive in_ready_o = (state==IDLE) and (!out_valid_o or out_ready_i), giving full throughput for single-cycle ops.
REQ-016 SHALL, for opcodes 0-9, register the result, tag and illegal_o=0 and raise out_valid_o on the cycle after acceptance, giving a latency of 1.
REQ-017 SHALL wrap ADD and SUB modulo 2^XLEN.
REQ-018 SHALL take the shift amount for SLL, SRL and SRA from op2[log2(XLEN)-1:0]; SRA sign-fills.
REQ-019 SHALL make SLT a signed compare and SLTU an unsigned compare, with the result zero-extended to 1 or 0.
REQ-020 SHALL treat opcodes 11-15 as illegal: result 0, tag passed through, illegal_o=1, latency 1.
REQ-021 SHALL hold op3_data_o, tag_o and illegal_o stable while out_valid_o=1 and out_ready_i=0.
REQ-022 SHALL clear out_valid_o when out_ready_i=1, unless a new operation completes in the same cycle, in which case out_valid_o stays 1 and the new result is loaded.
REQ-023 SHALL have state machine states IDLE and MUL_BUSY; IDLE->MUL_BUSY on MUL acceptance, and MUL_BUSY->IDLE when the iteration counter reaches XLEN and the result is written.
REQ-024 SHALL compute MUL as an iterative shift-add of op2 bits LSB-first, one bit per cycle, producing the low XLEN bits of the product; out_valid_o rises XLEN+1 cycles after acceptance.
REQ-025 SHALL have a MUL result that is independent of operand sign, because the low half is identical for signed and unsigned operands.
REQ-026 SHALL, on flush_i=1, force state to IDLE, clear the counter and clear out_valid_o next cycle; an operation offered in the same cycle as flush_i is not accepted (in_ready_o=0).

Reset
REQ-027 SHALL, on rst_i=1 at a clock edge, set out_valid_o=0, op3_data_o=0, tag_o=0, illegal_o=0, state=IDLE and the counter to 0.
REQ-028 SHALL have reset abort an in-progress MUL with no later output; in_ready_o is 1 on the first cycle after rst_i falls.

Configuration
REQ-029 SHALL, with macro TRIUMPH_EX_MUL_EN defined, implement MUL and the MUL_BUSY state per REQ-023 to REQ-025.
REQ-030 SHALL, without TRIUMPH_EX_MUL_EN, contain no multiplier, counter or MUL_BUSY state; opcode 10 is then treated as illegal per REQ-020 and the state stays IDLE.

Verification
REQ-031 SHALL be covered by this directed scenario: XLEN=32, ADD 0xFFFFFFFF+0x00000002, tag 3 -> next cycle out_valid_o=1, op3=0x00000001, tag_o=3, illegal_o=0.
REQ-032 SHALL be covered by this directed scenario: SRA 0x80000000 by op2=0x00000024 -> op3=0xF8000000, the shift amount being 4; SLT 0xFFFFFFFF vs 1 -> 1; SLTU on the same operands -> 0.
REQ-033 SHALL be covered by this directed scenario: back-to-back ADDs with out_ready_i=0 on the 2nd result cycle -> second result held stable, in_ready_o=0, no third acceptance until out_ready_i=1.
REQ-034 SHALL be covered by this directed scenario: with TRIUMPH_EX_MUL_EN, MUL 0x0000FFFF*0x00010001 -> out_valid_o exactly 33 cycles after acceptance, op3=0xFFFFFFFF, in_ready_o=0 throughout.
REQ-035 SHALL be covered by this directed scenario: MUL accepted, flush_i pulsed on cycle 10 -> no result ever appears, in_ready_o=1 on cycle 11; the same check repeated with rst_i in place of flush_i.
REQ-036 SHALL be covered by this directed scenario: without TRIUMPH_EX_MUL_EN, opcode 10, and separately opcode 15 -> latency 1, op3=0, illegal_o=1.

Source files
------------

// File: rtl/triumph_ex_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | triumph_ex_alu: 1-cycle integer ALU, optional iterative MUL (TRIUMPH_EX_MUL_EN)
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module triumph_ex_alu #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_type_i,
    input  logic [XLEN-1:0]  op1_data_i,
    input  logic [XLEN-1:0]  op2_data_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  op3_data_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             illegal_o
);

    localparam int c_SH_W = $clog2(XLEN);

    logic [XLEN-1:0]   r_res;
    logic [TAG_W-1:0]  r_tag;
    logic              r_ill;
    logic              r_out_valid;

    logic [XLEN-1:0]   w_alu_res;
    logic              w_alu_ill;
    logic [c_SH_W-1:0] w_shamt;
    logic              w_out_free;
    logic              w_accept;
    logic              w_load;
    logic [XLEN-1:0]   w_load_res;
    logic [TAG_W-1:0]  w_load_tag;
    logic              w_load_ill;

    assign w_shamt    = op2_data_i[c_SH_W-1:0];
    assign w_out_free = !r_out_valid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;

    always_comb begin
        w_alu_res = '0;
        w_alu_ill = 1'b0;
        case (op_type_i)
            4'd0:    w_alu_res = op1_data_i + op2_data_i;
            4'd1:    w_alu_res = op1_data_i - op2_data_i;
            4'd2:    w_alu_res = op1_data_i ^ op2_data_i;
            4'd3:    w_alu_res = op1_data_i | op2_data_i;
            4'd4:    w_alu_res = op1_data_i & op2_data_i;
            4'd5:    w_alu_res = op1_data_i << w_shamt;
            4'd6:    w_alu_res = op1_data_i >> w_shamt;
            4'd7:    w_alu_res = $signed(op1_data_i) >>> w_shamt;
            4'd8:    w_alu_res = {{(XLEN-1){1'b0}}, ($signed(op1_data_i) < $signed(op2_data_i))};
            4'd9:    w_alu_res = {{(XLEN-1){1'b0}}, (op1_data_i < op2_data_i)};
`ifdef TRIUMPH_EX_MUL_EN
            4'd10:   w_alu_res = '0;
`endif
            default: w_alu_ill = 1'b1;
        endcase
    end

`ifdef TRIUMPH_EX_MUL_EN
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam int                 c_CNT_W    = c_SH_W + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]    r_mcand;
    logic [XLEN-1:0]    r_mplier;
    logic [XLEN-1:0]    r_acc;
    logic [TAG_W-1:0]   r_mul_tag;
    logic [XLEN-1:0]    w_acc_nxt;
    logic               w_is_mul;
    logic               w_mul_step;
    logic               w_mul_last;

    assign w_is_mul   = (op_type_i == 4'd10);
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
    // The final step stalls while an unconsumed result still occupies the output.
    assign w_mul_step = (r_state == MUL_BUSY) && ((r_cnt != c_CNT_LAST) || w_out_free);
    assign w_mul_last = w_mul_step && (r_cnt == c_CNT_LAST);
    assign in_ready_o = (r_state == IDLE) && w_out_free && !flush_i;

    assign w_load     = (w_accept && !w_is_mul) || w_mul_last;
    assign w_load_res = w_mul_last ? w_acc_nxt : w_alu_res;
    assign w_load_tag = w_mul_last ? r_mul_tag : tag_i;
    assign w_load_ill = w_mul_last ? 1'b0 : w_alu_ill;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_accept && w_is_mul) w_state_nxt = MUL_BUSY;
            MUL_BUSY: if (w_mul_last) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
        if (flush_i) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_mul_tag <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_i) begin
                r_cnt <= '0;
            end else if (w_accept && w_is_mul) begin
                r_cnt     <= '0;
                r_mcand   <= op1_data_i;
                r_mplier  <= op2_data_i;
                r_acc     <= '0;
                r_mul_tag <= tag_i;
            end else if (w_mul_step) begin
                r_cnt    <= r_cnt + c_CNT_W'(1);
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end
    end
`else
    assign in_ready_o = w_out_free && !flush_i;
    assign w_load     = w_accept;
    assign w_load_res = w_alu_res;
    assign w_load_tag = tag_i;
    assign w_load_ill = w_alu_ill;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_tag       <= '0;
            r_ill       <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_res       <= w_load_res;
            r_tag       <= w_load_tag;
            r_ill       <= w_load_ill;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign op3_data_o  = r_res;
    assign tag_o       = r_tag;
    assign illegal_o   = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_triumph_ex_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_triumph_ex_alu: directed + random checks of triumph_ex_alu vs a model      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_triumph_ex_alu;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef TRIUMPH_EX_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       op_type = '0;
    logic [XLEN-1:0]  op1 = '0;
    logic [XLEN-1:0]  op2 = '0;
    logic [TAG_W-1:0] tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  op3;
    logic [TAG_W-1:0] tag_out;
    logic             illegal;

    int n_tests = 0;
    int n_fail  = 0;

    triumph_ex_alu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_type_i   (op_type),
        .op1_data_i  (op1),
        .op2_data_i  (op2),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .op3_data_o  (op3),
        .tag_o       (tag_out),
        .illegal_o   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model computed from the arithmetic definition of each opcode.
    function automatic void model(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                  output logic [XLEN-1:0] r, output logic ill);
        longint unsigned sh;
        logic [2*XLEN-1:0] prod;
        sh  = longint'(b) % XLEN;
        r   = '0;
        ill = 1'b0;
        case (op)
            4'd0: r = XLEN'((longint'(a) + longint'(b)) % (64'd1 << XLEN));
            4'd1: r = a - b;
            4'd2: r = a ^ b;
            4'd3: r = a | b;
            4'd4: r = a & b;
            4'd5: r = XLEN'(longint'(a) * (64'd1 << sh));
            4'd6: r = XLEN'(longint'(a) / (64'd1 << sh));
            4'd7: begin
                r = XLEN'(longint'(a) / (64'd1 << sh));
                if (a[XLEN-1]) r = r | ~(XLEN'({XLEN{1'b1}}) >> sh);
            end
            4'd8: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd9: r = (a < b) ? 1 : 0;
            4'd10: begin
                if (MUL_ON) begin
                    prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
                    r    = prod[XLEN-1:0];
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // Issue one op, wait for its result, check latency/value, hold it, then drain.
    task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] tg, output logic [XLEN-1:0] obs, output logic obs_ill);
        logic [XLEN-1:0] exp_r;
        logic            exp_ill;
        int              lat, cyc, hold;
        bit              busy_ok;
        model(op, a, b, exp_r, exp_ill);
        lat = (op == 4'd10 && MUL_ON) ? XLEN + 1 : 1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op_type   = op;
        op1       = a;
        op2       = b;
        tag       = tg;
        #1;
        check("issue_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        tag      = TAG_W'($urandom);
        cyc      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && cyc < XLEN + 10) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        check("latency", cyc, lat);
        check("in_ready_low_while_busy", busy_ok, 1);
        check("out_valid", out_valid, 1);
        check("op3", op3, exp_r);
        check("tag_o", tag_out, tg);
        check("illegal_o", illegal, exp_ill);
        obs     = op3;
        obs_ill = illegal;
        hold    = $urandom_range(0, 2);
        repeat (hold) tick();
        check("hold_op3", op3, exp_r);
        check("hold_tag", tag_out, tg);
        out_ready = 1'b1;
        tick();
        check("drained", out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [XLEN-1:0] r;
        logic            ill;
        bit              seen;
        logic [3:0]      rop;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_op3", op3, 0);
        check("rst_tag", tag_out, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed arithmetic
        issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, r, ill);
        check("add_wrap", r, 32'h0000_0001);
        issue(4'd7, 32'h8000_0000, 32'h0000_0024, 5'd4, r, ill);
        check("sra_fill", r, 32'hF800_0000);
        issue(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5, r, ill);
        check("slt_signed", r, 32'h1);
        issue(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, r, ill);
        check("sltu_unsigned", r, 32'h0);
        issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, r, ill);
        check("op15_result", r, 0);
        check("op15_illegal", ill, 1);
        issue(4'd11, 32'hDEAD_BEEF, 32'h1, 5'd8, r, ill);
        check("op11_illegal", ill, 1);
        issue(4'd10, 32'h0000_FFFF, 32'h0001_0001, 5'd9, r, ill);
        check("op10_illegal", ill, !MUL_ON);
        check("op10_result", r, MUL_ON ? 32'hFFFF_FFFF : 32'h0);

        // Back-to-back with backpressure
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_type   = 4'd0;
        op1 = 32'd10; op2 = 32'd20; tag = 5'd1;
        #1;
        check("b2b_ready1", in_ready, 1);
        tick();
        check("b2b_res1", op3, 32'd30);
        op1 = 32'd100; op2 = 32'd5; tag = 5'd2;
        #1;
        check("b2b_ready2", in_ready, 1);
        tick();
        check("b2b_valid2", out_valid, 1);
        check("b2b_res2", op3, 32'd105);
        out_ready = 1'b0;
        op1 = 32'd7; op2 = 32'd8; tag = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("b2b_stall_ready", in_ready, 0);
            tick();
            check("b2b_hold_valid", out_valid, 1);
            check("b2b_hold_res", op3, 32'd105);
            check("b2b_hold_tag", tag_out, 5'd2);
        end
        out_ready = 1'b1;
        #1;
        check("b2b_ready3", in_ready, 1);
        tick();
        check("b2b_valid3", out_valid, 1);
        check("b2b_res3", op3, 32'd15);
        check("b2b_tag3", tag_out, 5'd3);
        in_valid = 1'b0;
        tick();
        check("b2b_drain", out_valid, 0);

        // Flush on a held result; op offered with flush is refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op_type   = 4'd2; op1 = 32'hF0F0; op2 = 32'h0FF0; tag = 5'd11;
        tick();
        check("flush_pre_valid", out_valid, 1);
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_clears", out_valid, 0);
        tick();
        check("flush_no_accept", out_valid, 0);

        // Reset on a held result
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op_type   = 4'd3; op1 = 32'h5; op2 = 32'hA; tag = 5'd12;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_valid", out_valid, 0);
        check("rst2_op3", op3, 0);
        check("rst2_tag", tag_out, 0);
        check("rst2_in_ready", in_ready, 1);

`ifdef TRIUMPH_EX_MUL_EN
        issue(4'd10, 32'hFFFF_FFFD, 32'h0000_0005, 5'd13, r, ill);
        check("mul_signed_low", r, 32'hFFFF_FFF1);

        // MUL aborted by flush, then by reset, on cycle 10
        for (int k = 0; k < 2; k++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            op_type   = 4'd10; op1 = 32'h1234; op2 = 32'h5678; tag = 5'd14;
            #1;
            check("abort_accept", in_ready, 1);
            tick();
            in_valid = 1'b0;
            repeat (9) tick();
            if (k == 0) begin
                flush    = 1'b1;
                in_valid = 1'b1;
                op_type  = 4'd0;
                #1;
                check("abort_flush_ready", in_ready, 0);
            end else begin
                rst = 1'b1;
            end
            tick();
            flush    = 1'b0;
            rst      = 1'b0;
            in_valid = 1'b0;
            check("abort_in_ready_c11", in_ready, 1);
            seen = 1'b0;
            repeat (40) begin
                if (out_valid) seen = 1'b1;
                tick();
            end
            check("abort_no_result", seen, 0);
        end
`endif

        // Randomized ops against the model
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            issue(rop, $urandom, $urandom, TAG_W'($urandom), r, ill);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
